// File: rtl/mipi_csi_pkg.sv
// Shared types and helpers for the CSI-2 RX lane deskew path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mipi_csi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ALIGNED,
        DRAIN
    } deskew_state_t;

    // A lane count of 0, or one larger than the physical lane count, means
    // "use every physical lane".
    function automatic int clamp_lanes(input int lanes_active, input int lanes);
        if (lanes_active <= 0 || lanes_active > lanes) begin
            return lanes;
        end
        return lanes_active;
    endfunction

endpackage

// File: rtl/mipi_lane_delay_line.sv
// Per-lane shift register with a selectable tap, used to delay early lanes.
// Latency: tap_sel+1 cycles from din to dout (dout is a mux of registers).
// Backpressure: none; shifts every cycle.
//
// Ports:
//   clk_i, reset_i : byte clock, synchronous active-high reset (clears stages)
//   din            : {valid, byte} entering the line
//   tap_sel        : stage index to present on dout
//   dout           : selected stage
module mipi_lane_delay_line #(
    parameter int DEPTH = 4,
    parameter int W     = 9,
    localparam int TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [W-1:0]     din,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [W-1:0]     dout
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                sr[k] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    // Explicit compare mux so a tap value beyond DEPTH-1 (non power-of-two
    // depth) reads as zero rather than indexing out of range.
    always_comb begin
        dout = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_sel == TAP_W'(k)) begin
                dout = sr[k];
            end
        end
    end

endmodule

// File: rtl/mipi_rx_lane_deskew.sv
// Aligns 1..LANES active CSI-2 lanes with up to MAX_SKEW cycles of skew.
// Latency: first word 1 cycle after the last lane's first valid byte.
// Backpressure: none; misaligned packets are dropped and flagged on skew_err_o.
//
// Ports:
//   clk_i, reset_i  : byte clock, synchronous active-high reset
//   lanes_active_i  : active lane count (0 or >LANES means LANES), sampled at packet start
//   bytes_valid_i   : per-lane byte valid
//   byte_i          : per-lane bytes, lane n at [8n+7:8n]
//   lane_valid_o    : aligned word valid
//   lane_byte_o     : aligned bytes, zero for inactive lanes and invalid cycles
//   skew_o          : arrival spread of the last successfully aligned packet
//   skew_err_o      : one-cycle pulse when a packet cannot be aligned
module mipi_rx_lane_deskew
    import mipi_csi_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int MAX_SKEW = 3,
    parameter int CNT_W    = $clog2(LANES) + 1,
    parameter int SKW_W    = $clog2(MAX_SKEW + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [CNT_W-1:0]          lanes_active_i,
    input  logic [LANES-1:0]          bytes_valid_i,
    input  logic [BYTE_W*LANES-1:0]   byte_i,
    output logic                      lane_valid_o,
    output logic [BYTE_W*LANES-1:0]   lane_byte_o,
    output logic [SKW_W-1:0]          skew_o,
    output logic                      skew_err_o
);

    deskew_state_t    state_q, state_d;
    logic [LANES-1:0] act_q, act_d;          // active-lane mask latched at packet start
    logic [LANES-1:0] mask_in;               // mask decoded from lanes_active_i
    logic [LANES-1:0] act_now;
    logic [LANES-1:0] vld_act;
    logic [LANES-1:0] arrived_q, arrived_d;
    logic [LANES-1:0] arr_all;
    logic [SKW_W-1:0] cnt_q, cnt_d;
    logic [SKW_W-1:0] skew_q, skew_d;
    logic [SKW_W-1:0] arrival_q [LANES];
    logic [SKW_W-1:0] arrival_d [LANES];
    logic [SKW_W-1:0] tap_q [LANES];
    logic [SKW_W-1:0] tap_d [LANES];
    logic             err_d, err_q;
    logic [LANES-1:0] tvld;
    logic [BYTE_W-1:0] tbyte [LANES];
    logic             aligned_vld;

    // ------------------------------------------------------------------
    // Per-lane delay lines. They shift continuously so that, once taps are
    // latched, every lane's history is already in place.
    // ------------------------------------------------------------------
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [BYTE_W:0] dl_out;

        mipi_lane_delay_line #(
            .DEPTH (MAX_SKEW + 1),
            .W     (BYTE_W + 1)
        ) u_delay (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .din     ({bytes_valid_i[n], byte_i[n*BYTE_W +: BYTE_W]}),
            .tap_sel (tap_q[n]),
            .dout    (dl_out)
        );

        assign tvld[n]  = dl_out[BYTE_W];
        assign tbyte[n] = dl_out[BYTE_W-1:0];
    end

    // ------------------------------------------------------------------
    // Active-lane decode. The live count only matters in IDLE; afterwards
    // the latched mask governs the whole packet.
    // ------------------------------------------------------------------
    always_comb begin
        int n_now;
        n_now   = clamp_lanes(int'(lanes_active_i), LANES);
        mask_in = '0;
        for (int n = 0; n < LANES; n++) begin
            mask_in[n] = (n < n_now);
        end
    end

    assign act_now     = (state_q == IDLE) ? mask_in : act_q;
    assign vld_act     = bytes_valid_i & act_now;
    assign arr_all     = arrived_q | vld_act;
    assign aligned_vld = &(tvld | ~act_q);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        arrived_d = arrived_q;
        cnt_d     = cnt_q;
        skew_d    = skew_q;
        err_d     = 1'b0;
        arrival_d = arrival_q;
        tap_d     = tap_q;

        unique case (state_q)
            IDLE: begin
                if (|vld_act) begin
                    act_d     = mask_in;
                    arrived_d = vld_act;
                    cnt_d     = SKW_W'(1);
                    for (int n = 0; n < LANES; n++) begin
                        arrival_d[n] = '0;
                        tap_d[n]     = '0;
                    end
                    if (vld_act == mask_in) begin
                        // Every active lane started together: zero skew.
                        skew_d  = '0;
                        state_d = ALIGNED;
                    end else begin
                        state_d = ARM;
                    end
                end
            end

            ARM: begin
                if (|(arrived_q & ~bytes_valid_i)) begin
                    // A lane that already started went quiet before the
                    // stragglers showed up: the packet is unusable.
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else if (arr_all == act_q) begin
                    // Lanes arriving this cycle are the latest; they get tap 0.
                    for (int n = 0; n < LANES; n++) begin
                        tap_d[n] = arrived_q[n] ? SKW_W'(cnt_q - arrival_q[n]) : '0;
                    end
                    skew_d  = cnt_q;
                    state_d = ALIGNED;
                end else if (cnt_q == SKW_W'(MAX_SKEW)) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    for (int n = 0; n < LANES; n++) begin
                        if (vld_act[n] && !arrived_q[n]) begin
                            arrival_d[n] = cnt_q;
                        end
                    end
                    arrived_d = arr_all;
                    cnt_d     = SKW_W'(cnt_q + 1'b1);
                end
            end

            ALIGNED: begin
                if (!aligned_vld) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (vld_act == '0) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            act_q     <= '0;
            arrived_q <= '0;
            cnt_q     <= '0;
            skew_q    <= '0;
            err_q     <= 1'b0;
            for (int n = 0; n < LANES; n++) begin
                arrival_q[n] <= '0;
                tap_q[n]     <= '0;
            end
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            arrived_q <= arrived_d;
            cnt_q     <= cnt_d;
            skew_q    <= skew_d;
            err_q     <= err_d;
            arrival_q <= arrival_d;
            tap_q     <= tap_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: derived only from registered state and delay-line stages.
    // ------------------------------------------------------------------
    assign lane_valid_o = (state_q == ALIGNED) && aligned_vld;
    assign skew_o       = skew_q;
    assign skew_err_o   = err_q;

    always_comb begin
        lane_byte_o = '0;
        for (int n = 0; n < LANES; n++) begin
            if (lane_valid_o && act_q[n]) begin
                lane_byte_o[n*BYTE_W +: BYTE_W] = tbyte[n];
            end
        end
    end

endmodule

// File: tb/tb_mipi_rx_lane_deskew.sv
module tb_mipi_rx_lane_deskew;

    localparam int LANES    = 4;
    localparam int MAX_SKEW = 3;
    localparam int CNT_W    = $clog2(LANES) + 1;
    localparam int SKW_W    = $clog2(MAX_SKEW + 1);
    localparam int TMAX     = 32;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [CNT_W-1:0]       lanes_active_i;
    logic [LANES-1:0]       bytes_valid_i;
    logic [8*LANES-1:0]     byte_i;
    logic                   lane_valid_o;
    logic [8*LANES-1:0]     lane_byte_o;
    logic [SKW_W-1:0]       skew_o;
    logic                   skew_err_o;

    mipi_rx_lane_deskew #(
        .LANES    (LANES),
        .MAX_SKEW (MAX_SKEW)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .lanes_active_i (lanes_active_i),
        .bytes_valid_i  (bytes_valid_i),
        .byte_i         (byte_i),
        .lane_valid_o   (lane_valid_o),
        .lane_byte_o    (lane_byte_o),
        .skew_o         (skew_o),
        .skew_err_o     (skew_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Packet description consumed by run_packet.
    int pk_la0;            // lanes_active driven at packet start
    int pk_la1;            // lanes_active driven from pk_chg onward
    int pk_chg;            // cycle at which lanes_active switches (0 = never)
    int pk_rst;            // cycle at which reset is pulsed (0 = never)
    int pk_len;            // bytes per lane
    int pk_fixed;          // 1 = recognisable byte pattern, 0 = random bytes
    int pk_off [LANES];    // start offset of each lane within the window
    int cur_skew = 0;      // skew the DUT should currently report

    task automatic set_pk(input int la0, input int la1, input int chg, input int rst,
                          input int len, input int fixed);
        pk_la0 = la0; pk_la1 = la1; pk_chg = chg; pk_rst = rst;
        pk_len = len; pk_fixed = fixed;
    endtask

    task automatic set_off(input int o0, input int o1, input int o2, input int o3);
        pk_off[0] = o0; pk_off[1] = o1; pk_off[2] = o2; pk_off[3] = o3;
    endtask

    // Reference model: a packet whose active lanes span at most MAX_SKEW
    // cycles is emitted word by word starting one cycle after the latest
    // lane's first byte; otherwise only an error pulse appears MAX_SKEW+1
    // cycles after the earliest lane started.
    task automatic run_packet();
        logic [LANES-1:0]   sv  [TMAX];
        logic [8*LANES-1:0] sb  [TMAX];
        int                 sla [TMAX];
        logic               srst[TMAX];
        logic               ev  [TMAX];
        logic [8*LANES-1:0] eb  [TMAX];
        logic               ee  [TMAX];
        int                 es  [TMAX];
        logic [7:0]         d   [LANES][16];
        int nl, smin, smax, spread, tlen;

        nl = (pk_la0 <= 0 || pk_la0 > LANES) ? LANES : pk_la0;
        smin = pk_off[0];
        smax = pk_off[0];
        for (int n = 1; n < nl; n++) begin
            if (pk_off[n] < smin) smin = pk_off[n];
            if (pk_off[n] > smax) smax = pk_off[n];
        end
        spread = smax - smin;
        tlen   = 1 + smax + pk_len + 4;

        for (int n = 0; n < LANES; n++) begin
            for (int k = 0; k < 16; k++) begin
                d[n][k] = pk_fixed ? 8'((n + 1) * 17 + k) : 8'($urandom);
            end
        end

        for (int c = 0; c < TMAX; c++) begin
            sv[c]   = '0;
            sla[c]  = (pk_chg > 0 && c >= pk_chg) ? pk_la1 : pk_la0;
            srst[c] = 1'b0;
            for (int n = 0; n < LANES; n++) begin
                sb[c][8*n +: 8] = 8'($urandom);
                if (n >= nl && pk_chg == 0) sv[c][n] = 1'($urandom);
            end
            ev[c] = 1'b0;
            eb[c] = '0;
            ee[c] = 1'b0;
            es[c] = cur_skew;
        end

        for (int n = 0; n < nl; n++) begin
            for (int k = 0; k < pk_len; k++) begin
                sv[1 + pk_off[n] + k][n]        = 1'b1;
                sb[1 + pk_off[n] + k][8*n +: 8] = d[n][k];
            end
        end

        if (spread <= MAX_SKEW) begin
            for (int k = 0; k < pk_len; k++) begin
                ev[2 + smax + k] = 1'b1;
                for (int n = 0; n < nl; n++) begin
                    eb[2 + smax + k][8*n +: 8] = d[n][k];
                end
            end
            for (int c = 2 + smax; c < TMAX; c++) es[c] = spread;
            cur_skew = spread;
        end else begin
            ee[1 + smin + MAX_SKEW + 1] = 1'b1;
        end

        if (pk_rst > 0) begin
            srst[pk_rst] = 1'b1;
            for (int c = pk_rst; c < TMAX; c++) sv[c] = '0;
            for (int c = pk_rst + 1; c < TMAX; c++) begin
                ev[c] = 1'b0;
                eb[c] = '0;
                ee[c] = 1'b0;
                es[c] = 0;
            end
            cur_skew = 0;
        end

        for (int c = 0; c < tlen; c++) begin
            @(posedge clk_i);
            #1;
            check("lane_valid", lane_valid_o, ev[c]);
            check("lane_byte",  lane_byte_o,  eb[c]);
            check("skew",       skew_o,       es[c]);
            check("skew_err",   skew_err_o,   ee[c]);
            bytes_valid_i  = sv[c];
            byte_i         = sb[c];
            lanes_active_i = CNT_W'(sla[c]);
            reset_i        = srst[c];
        end
    endtask

    initial begin
        reset_i        = 1'b1;
        bytes_valid_i  = '0;
        byte_i         = '0;
        lanes_active_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", lane_valid_o, 1'b0);
        check("rst_byte",  lane_byte_o,  '0);
        check("rst_skew",  skew_o,       '0);
        check("rst_err",   skew_err_o,   1'b0);
        reset_i = 1'b0;

        // All lanes together, recognisable bytes.
        set_pk(4, 4, 0, 0, 6, 1); set_off(0, 0, 0, 0); run_packet();
        // Maximum legal skew.
        set_pk(4, 4, 0, 0, 7, 1); set_off(0, 1, 3, 2); run_packet();
        // One beyond the legal skew.
        set_pk(4, 4, 0, 0, 7, 0); set_off(0, 1, 4, 2); run_packet();
        // Two active lanes, garbage on the others.
        set_pk(2, 2, 0, 0, 6, 0); set_off(0, 1, 0, 0); run_packet();
        // Single lane.
        set_pk(1, 1, 0, 0, 5, 0); set_off(2, 0, 0, 0); run_packet();
        // Reset in the middle of an aligned packet, then a normal packet.
        set_pk(4, 4, 0, 0, 6, 0); set_off(0, 2, 1, 0); run_packet();
        set_pk(4, 4, 0, 5, 8, 0); set_off(0, 0, 0, 0); run_packet();
        set_pk(4, 4, 0, 0, 6, 0); set_off(1, 0, 2, 1); run_packet();
        // Lane count changed while aligned; next packet uses the new count.
        set_pk(4, 2, 6, 0, 8, 0); set_off(0, 1, 0, 1); run_packet();
        set_pk(2, 2, 0, 0, 6, 0); set_off(1, 0, 0, 0); run_packet();

        for (int i = 0; i < 40; i++) begin
            set_pk($urandom_range(0, 7), 0, 0, 0, $urandom_range(MAX_SKEW + 2, MAX_SKEW + 6), 0);
            pk_la1 = pk_la0;
            for (int n = 0; n < LANES; n++) pk_off[n] = $urandom_range(0, MAX_SKEW + 1);
            run_packet();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
